// File: rtl/envelope_pwm_gate.sv
`default_nettype none
// ============================================================================
// envelope_pwm_gate: ADSR amplitude envelope applied as a PWM duty mask on a
// 1-bit square-wave tone.  Revision: 1.0
// ============================================================================
module envelope_pwm_gate #(
  parameter int TICK_DIV      = 1024,
  parameter int ATTACK_STEP   = 16,
  parameter int DECAY_STEP    = 4,
  parameter int SUSTAIN_LEVEL = 160,
  parameter int RELEASE_STEP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tone_in,
  input  logic       gate,
  output logic       audio_out,
  output logic [7:0] level,
  output logic [2:0] env_state,
  output logic       busy
);

  localparam int             TCW       = $clog2(TICK_DIV);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

  localparam logic [8:0] ATK_STEP9     = 9'(ATTACK_STEP);
  localparam logic [7:0] DEC_STEP8     = 8'(DECAY_STEP);
  localparam logic [7:0] SUS_LVL8      = 8'(SUSTAIN_LEVEL);
  localparam logic [8:0] SUS_PLUS_DEC9 = 9'(SUSTAIN_LEVEL + DECAY_STEP);
  localparam logic [7:0] REL_STEP8     = 8'(RELEASE_STEP);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [TCW-1:0] tick_cnt_q;
  logic [7:0]     pwm_cnt_q;
  logic           gate_q;
  logic           audio_q;
  logic [2:0]     state_q, state_d;
  logic [7:0]     level_q, level_d;

  logic           env_tick;
  logic           rise;
  logic           fall;
  logic           pwm_on;
  logic [8:0]     atk_sum;
  logic [7:0]     dec_val;
  logic [7:0]     rel_val;

  assign env_tick = (tick_cnt_q == TICK_LAST);
  assign rise     = gate & ~gate_q;
  assign fall     = ~gate & gate_q;
  assign pwm_on   = (pwm_cnt_q < level_q);

  // Saturating arithmetic: compare before subtracting so nothing wraps.
  assign atk_sum  = {1'b0, level_q} + ATK_STEP9;
  assign dec_val  = ({1'b0, level_q} >= SUS_PLUS_DEC9) ? (level_q - DEC_STEP8) : SUS_LVL8;
  assign rel_val  = (level_q > REL_STEP8) ? (level_q - REL_STEP8) : 8'd0;

  // Envelope state and level register together so they always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      level_q <= 8'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= 8'd0;
      gate_q     <= 1'b0;
      audio_q    <= 1'b0;
    end else begin
      tick_cnt_q <= env_tick ? '0 : tick_cnt_q + TCW'(1);
      pwm_cnt_q  <= pwm_cnt_q + 8'd1;
      gate_q     <= gate;
      audio_q    <= tone_in & pwm_on;
    end
  end

  // Gate edges win over the envelope tick: transition only, level untouched.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      state_d = S_ATTACK;
    end else if (fall) begin
      if (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN) begin
        state_d = S_RELEASE;
      end
    end else if (env_tick) begin
      case (state_q)
        S_ATTACK: begin
          if (atk_sum >= 9'd255) begin
            level_d = 8'd255;
            state_d = S_DECAY;
          end else begin
            level_d = atk_sum[7:0];
          end
        end
        S_DECAY: begin
          level_d = dec_val;
          if (dec_val == SUS_LVL8) begin
            state_d = S_SUSTAIN;
          end
        end
        S_SUSTAIN: begin
          level_d = level_q;
        end
        S_RELEASE: begin
          level_d = rel_val;
          if (rel_val == 8'd0) begin
            state_d = S_IDLE;
          end
        end
        S_IDLE: begin
          level_d = 8'd0;
        end
        default: begin
          state_d = S_IDLE;
          level_d = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    env_state = state_q;
    busy      = (state_q != S_IDLE);
  end

  assign level     = level_q;
  assign audio_out = audio_q;

endmodule
`default_nettype wire
